// File: rtl/alu_ops_pkg.sv
// ALU op code constants, legality check and arbiter FSM state type.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: OP_AND/OP_OR/OP_ADD/OP_SUB/OP_SLT codes, is_legal_op(), arb_state_t.
// Shared by the ALU control decode and alu_share_arbiter.
package alu_ops_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin requester pick, starting after the previous winner.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is used.
// Ports: req (valid per requester), last_grant (previous winner index),
//        lock (ALU_ARB_LOCK_EN only), grant (one-hot), grant_idx (encoded).
// Macro ALU_ARB_LOCK_EN: a locked, still-requesting previous winner keeps the grant.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0] lock,
`endif
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic found;
  int   cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    // Walk last_grant+1 .. last_grant+NREQ (mod NREQ); the previous winner is
    // checked last so a lone requester still gets back-to-back grants.
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDW'(cand);
      end
    end
`ifdef ALU_ARB_LOCK_EN
    if (lock[last_grant] && req[last_grant]) begin
      grant             = '0;
      grant[last_grant] = 1'b1;
      grant_idx         = last_grant;
    end
`endif
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU among NREQ requesters, one op in flight.
// Latency: request handshake in cycle T -> rsp_valid in cycle T+2; peak one op per 2 cycles.
// Backpressure: rsp_* held until rsp_ready; req_ready low in EXEC and in RESP while rsp_ready=0.
// Ports: req_valid/req_ready/req_a/req_b/req_op (packed per requester),
//        rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_zero/rsp_err,
//        alu_a/alu_b/alu_signal (registered to ALU), alu_result/alu_zero (from ALU), busy.
// Macro ALU_ARB_LOCK_EN: adds req_lock so the last winner can keep the ALU.
module alu_share_arbiter
  import alu_ops_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [3*NREQ-1:0]    req_op,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_zero,
  output logic                 rsp_err,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_signal,
  input  logic [31:0]          alu_result,
  input  logic                 alu_zero,
  output logic                 busy
);

  arb_state_t      state;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  id_q;
  logic            err_q;

  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  arb_idx;
  logic            grant_en;
  logic            hs;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [2:0]      sel_op;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
`ifdef ALU_ARB_LOCK_EN
    .lock       (req_lock),
`endif
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  // A new op can be taken when idle, or when the pending response leaves this cycle.
  assign grant_en  = !reset && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
  assign req_ready = grant_en ? arb_grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == IDW'(i)) begin
        sel_a  = req_a[i*32 +: 32];
        sel_b  = req_b[i*32 +: 32];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(NREQ - 1);
      id_q       <= '0;
      err_q      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_signal <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      // hs can only be true in IDLE or in RESP while the response is taken.
      if (hs) begin
        alu_a      <= sel_a;
        alu_b      <= sel_b;
        // Illegal codes still run (as ADD) so the pipeline timing never changes.
        alu_signal <= is_legal_op(sel_op) ? sel_op : OP_ADD;
        err_q      <= !is_legal_op(sel_op);
        id_q       <= arb_idx;
        last_grant <= arb_idx;
      end
      case (state)
        ST_IDLE: begin
          if (hs) state <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          rsp_err   <= err_q;
          rsp_data  <= err_q ? 32'd0 : alu_result;
          rsp_zero  <= err_q | alu_zero;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= hs ? ST_EXEC : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic against a reference model.
// Latency: n/a.
// Backpressure: rsp_ready driven with a configurable acceptance probability.
module tb_alu_share_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [3*NREQ-1:0]   req_op;
`ifdef ALU_ARB_LOCK_EN
  logic [NREQ-1:0]     req_lock;
`endif
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_data;
  logic                rsp_zero;
  logic                rsp_err;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic [2:0]          alu_signal;
  logic [31:0]         alu_result;
  logic                alu_zero;
  logic                busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
`ifdef ALU_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_signal (alu_signal),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy)
  );

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit legal(input logic [2:0] op);
    return op inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111};
  endfunction

  // External ALU.
  always_comb begin
    alu_result = alu_fn(alu_signal, alu_a, alu_b);
    alu_zero   = (alu_result == 32'd0);
  end

  // Requester-side state: a pending request stays on the bus until granted.
  bit          pend  [NREQ];
  logic [31:0] pa    [NREQ];
  logic [31:0] pb    [NREQ];
  logic [2:0]  pop   [NREQ];
  bit          plock [NREQ];
  int          gen_prob = 0;
  int          rdy_prob = 100;
  bit          rst_drv  = 1'b1;

  // Reference model: last winner plus the single op in flight and its age.
  int          m_last = NREQ - 1;
  bit          m_inflight = 1'b0;
  int          m_age = 0;
  int          m_id = 0;
  logic [31:0] m_a, m_b, m_data;
  logic [2:0]  m_sig;
  bit          m_zero, m_err;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick();
`ifdef ALU_ARB_LOCK_EN
    if (plock[m_last] && pend[m_last]) return m_last;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    pend[i] = 1'b1;
    pa[i]   = a;
    pb[i]   = b;
    pop[i]  = op;
  endtask

  task automatic step();
    bit          visible;
    bit          allowed;
    int          win;
    logic [31:0] exp_ready;
    @(negedge clk);
    reset = rst_drv;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && ($urandom_range(99) < gen_prob)) begin
        pa[i]  = $urandom;
        pb[i]  = ($urandom_range(3) == 0) ? pa[i] : $urandom;
        pop[i] = 3'($urandom_range(7));
        pend[i] = 1'b1;
      end
      req_valid[i] = pend[i];
      // Non-pending requesters drive junk: only the latched copy may matter.
      req_a[i*32 +: 32] = pend[i] ? pa[i] : $urandom;
      req_b[i*32 +: 32] = pend[i] ? pb[i] : $urandom;
      req_op[i*3 +: 3]  = pend[i] ? pop[i] : 3'($urandom_range(7));
`ifdef ALU_ARB_LOCK_EN
      req_lock[i] = plock[i];
`endif
    end
    rsp_ready = ($urandom_range(99) < rdy_prob);
    if (rst_drv) begin
      m_inflight = 1'b0;
      m_age      = 0;
      m_last     = NREQ - 1;
    end
    #2;
    visible   = m_inflight && (m_age >= 1);
    allowed   = !rst_drv && (!m_inflight || (visible && rsp_ready));
    win       = allowed ? rr_pick() : -1;
    exp_ready = (win >= 0) ? (32'd1 << win) : 32'd0;
    check("req_ready", 32'(req_ready), exp_ready);
    check("rsp_valid", 32'(rsp_valid), 32'(visible));
    check("busy", 32'(busy), 32'(m_inflight));
    if (visible) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_data", rsp_data, m_data);
      check("rsp_zero", 32'(rsp_zero), 32'(m_zero));
      check("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    if (m_inflight && (m_age == 0)) begin
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_signal", 32'(alu_signal), 32'(m_sig));
    end
    if (rst_drv) begin
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_alu_signal", 32'(alu_signal), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
    end else begin
      if (visible && rsp_ready) m_inflight = 1'b0;
      else if (m_inflight) m_age++;
      if (win >= 0) begin
        m_inflight = 1'b1;
        m_age      = 0;
        m_last     = win;
        m_id       = win;
        m_a        = pa[win];
        m_b        = pb[win];
        m_err      = !legal(pop[win]);
        m_sig      = m_err ? 3'b010 : pop[win];
        m_data     = m_err ? 32'd0 : alu_fn(pop[win], pa[win], pb[win]);
        m_zero     = (m_data == 32'd0);
        pend[win]  = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; plock[i] = 1'b0; pa[i] = '0; pb[i] = '0; pop[i] = '0;
    end

    // Reset with a request already waiting: no grant while reset is high.
    rst_drv = 1'b1;
    set_req(0, 32'd5, 32'd7, 3'b010);
    run(2);
    // Single ADD 5+7 from requester 0.
    rst_drv = 1'b0;
    run(6);

    // Both requesters continuously valid: alternating grants.
    gen_prob = 100;
    run(12);
    gen_prob = 0;
    run(6);

    // SUB 9-9 from requester 1 with the response stalled for several cycles.
    set_req(1, 32'd9, 32'd9, 3'b110);
    rdy_prob = 0;
    run(8);
    rdy_prob = 100;
    run(4);

    // Illegal op code.
    set_req(0, 32'd3, 32'd4, 3'b100);
    run(6);

    // Reset during EXEC, then requester 0 must win first.
    set_req(1, 32'h11, 32'h22, 3'b010);
    run(3);
    set_req(0, 32'd1, 32'd2, 3'b010);
    step();
    @(posedge clk);
    #2;
    rst_drv = 1'b1;
    reset   = 1'b1;
    set_req(0, 32'd8, 32'd1, 3'b110);
    set_req(1, 32'd8, 32'd2, 3'b110);
    run(2);
    rst_drv = 1'b0;
    run(8);

`ifdef ALU_ARB_LOCK_EN
    // Requester 0 holds the lock while both request, then releases it.
    plock[0] = 1'b1;
    gen_prob = 100;
    run(8);
    plock[0] = 1'b0;
    run(6);
    gen_prob = 0;
    run(6);
`endif

    // Random traffic with random backpressure.
    gen_prob = 50;
    rdy_prob = 60;
    for (int c = 0; c < 400; c++) begin
`ifdef ALU_ARB_LOCK_EN
      for (int i = 0; i < NREQ; i++) plock[i] = ($urandom_range(3) == 0);
`endif
      step();
    end
    gen_prob = 0;
    rdy_prob = 100;
`ifdef ALU_ARB_LOCK_EN
    for (int i = 0; i < NREQ; i++) plock[i] = 1'b0;
`endif
    run(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
